// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RDATA,
    ST_WACK,
    ST_RESP
  } state_e;

  localparam int BEATS       = 8;   // beats per cache line
  localparam int BEAT_W      = 3;   // width of the beat counter
  localparam int OFFSET_BITS = 6;   // byte-offset bits inside a 64-byte line
  localparam int MAX_ADDR_W  = 64;

  // Align an address down to the start of its cache line.
  function automatic logic [MAX_ADDR_W-1:0] line_addr(input logic [MAX_ADDR_W-1:0] addr);
    return addr & ~((MAX_ADDR_W'(1) << OFFSET_BITS) - MAX_ADDR_W'(1));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between pending ports; favours the port not granted last.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
//   pend_i      pending request per port
//   last_gnt_i  port granted most recently
//   gnt_port_o  winning port, gnt_valid_o  at least one port pending
module rr_arb2 (
  input  logic [1:0] pend_i,
  input  logic       last_gnt_i,
  output logic       gnt_port_o,
  output logic       gnt_valid_o
);

  always_comb begin
    gnt_valid_o = |pend_i;
    case (pend_i)
      2'b01:   gnt_port_o = 1'b0;
      2'b10:   gnt_port_o = 1'b1;
      2'b11:   gnt_port_o = ~last_gnt_i;
      default: gnt_port_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one beat-based memory bus between the I-cache (port 0) and D-cache (port 1).
// Latency: read response 11 cycles after req, write response 4 cycles after req (immediate gnt, back-to-back beats).
// Backpressure: bus_req held until bus_gnt; each port holds one pending request, extra reqs while pending are dropped.
//   req_*_i      one-cycle request pulse per port with write flag, address and write data
//   rsp_*_o      per-port one-cycle completion pulse and last returned line
//   bus_*        single outstanding bus transaction: request/grant, read beats, write ack
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESSSIZE = 64,
  parameter int WIDTH       = 64,
  parameter int BLOCKSZ     = 512
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [1:0]                  req_i,
  input  logic [1:0]                  req_wr_en_i,
  input  logic [1:0][ADDRESSSIZE-1:0] req_addr_i,
  input  logic [1:0][WIDTH-1:0]       req_wdata_i,
  output logic [1:0][BLOCKSZ-1:0]     rsp_data_o,
  output logic [1:0]                  rsp_valid_o,
  output logic                        bus_req_o,
  output logic [ADDRESSSIZE-1:0]      bus_addr_o,
  output logic                        bus_we_o,
  output logic [WIDTH-1:0]            bus_wdata_o,
  input  logic                        bus_gnt_i,
  input  logic [WIDTH-1:0]            bus_rdata_i,
  input  logic                        bus_rvalid_i,
  input  logic                        bus_wack_i
);

  state_e                        state_q;
  logic [1:0]                    pend_q, pend_d;
  logic [1:0]                    pwe_q;
  logic [1:0][ADDRESSSIZE-1:0]   paddr_q;
  logic [1:0][WIDTH-1:0]         pwdata_q;
  logic                          last_gnt_q;
  logic                          cur_port_q;
  logic                          cur_we_q;
  logic [BEAT_W-1:0]             beat_q;
  logic [BLOCKSZ-1:0]            line_q, line_d;
  logic [1:0][BLOCKSZ-1:0]       rsp_data_q;
  logic [1:0]                    rsp_valid_q;
  logic                          bus_req_q;
  logic [ADDRESSSIZE-1:0]        bus_addr_q;
  logic                          bus_we_q;
  logic [WIDTH-1:0]              bus_wdata_q;

  logic                          gnt_port;
  logic                          gnt_valid;
  logic                          grant;
  logic [1:0]                    take;

  rr_arb2 u_rr_arb2 (
    .pend_i      (pend_q),
    .last_gnt_i  (last_gnt_q),
    .gnt_port_o  (gnt_port),
    .gnt_valid_o (gnt_valid)
  );

  assign grant = (state_q == ST_IDLE) && gnt_valid;

  always_comb begin
    take   = 2'b00;
    pend_d = pend_q;
    for (int p = 0; p < 2; p++) begin
      // A port whose pending slot empties this cycle may refill it in the same cycle,
      // so a req coinciding with its own grant is not lost.
      take[p] = req_i[p] && (!pend_q[p] || (grant && (gnt_port == p[0])));
      if (grant && (gnt_port == p[0])) pend_d[p] = 1'b0;
      if (take[p])                     pend_d[p] = 1'b1;
    end
  end

  // Line with the current beat merged in, so the final beat is already part
  // of the line that gets copied into rsp_data on the RDATA->RESP edge.
  always_comb begin
    line_d = line_q;
    if (state_q == ST_RDATA && bus_rvalid_i) begin
      line_d[int'(beat_q)*WIDTH +: WIDTH] = bus_rdata_i;
    end
  end

  // Pending request latches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q   <= '0;
      pwe_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      pend_q <= pend_d;
      for (int p = 0; p < 2; p++) begin
        if (take[p]) begin
          pwe_q[p]    <= req_wr_en_i[p];
          pwdata_q[p] <= req_wdata_i[p];
          paddr_q[p]  <= req_wr_en_i[p] ? req_addr_i[p]
                         : ADDRESSSIZE'(line_addr(MAX_ADDR_W'(req_addr_i[p])));
        end
      end
    end
  end

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= 1'b1;
      cur_port_q  <= 1'b0;
      cur_we_q    <= 1'b0;
      beat_q      <= '0;
      line_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_wdata_q <= '0;
    end else begin
      line_q <= line_d;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            cur_port_q  <= gnt_port;
            cur_we_q    <= pwe_q[gnt_port];
            last_gnt_q  <= gnt_port;
            bus_req_q   <= 1'b1;
            bus_addr_q  <= paddr_q[gnt_port];
            bus_we_q    <= pwe_q[gnt_port];
            bus_wdata_q <= pwdata_q[gnt_port];
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus_gnt_i) begin
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= '0;
            beat_q      <= '0;
            state_q     <= cur_we_q ? ST_WACK : ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (bus_rvalid_i) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == BEAT_W'(BEATS-1)) begin
              rsp_data_q[cur_port_q]  <= line_d;
              rsp_valid_q[cur_port_q] <= 1'b1;
              state_q                 <= ST_RESP;
            end
          end
        end
        ST_WACK: begin
          if (bus_wack_i) begin
            rsp_valid_q[cur_port_q] <= 1'b1;
            state_q                 <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid_q <= '0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_data_o  = rsp_data_q;
  assign rsp_valid_o = rsp_valid_q;
  assign bus_req_o   = bus_req_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_we_o    = bus_we_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule
